// File: rtl/serial_sub_4b_if.sv
// Operand/result bundle for the bit-serial subtractor: start handshake, operands and registered results.
interface serial_sub_4b_if #(
   parameter int unsigned WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             busy;
   logic             done;

   modport master (
      output start, a, b, bin,
      input  diff, bout, busy, done
   );

   modport slave (
      input  start, a, b, bin,
      output diff, bout, busy, done
   );
endinterface

// File: rtl/serial_sub_4b.sv
// Bit-serial borrow-ripple subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single borrow flop replaces the combinational borrow chain; start/busy/done handshake.
module serial_sub_4b #(
   parameter int unsigned WIDTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   serial_sub_4b_if.slave  bus
);
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             d_bit;
   logic             br_nx;
   logic [WIDTH-1:0] work_sh;

   // One full-subtractor slice on the current LSBs of the latched operands
   always_comb begin
      d_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
      br_nx   = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
      work_sh = {d_bit, work_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         work_q  <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         work_q  <= work_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      work_d  = work_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               sa_d    = bus.a;
               sb_d    = bus.b;
               br_d    = bus.bin;
               work_d  = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sa_d   = sa_q >> 1;
            sb_d   = sb_q >> 1;
            br_d   = br_nx;
            work_d = work_sh;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               diff_d  = work_sh;
               bout_d  = br_nx;
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Status flags are registered copies of the state being entered
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule

// File: tb/tb_serial_sub_4b.sv
// Scoreboard bench for serial_sub_4b: driver pushes expected {bout,diff}, monitor pops on done.
module tb_serial_sub_4b;
   localparam int unsigned WIDTH = 4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   logic [WIDTH:0] exp_q[$];

   serial_sub_4b_if #(.WIDTH(WIDTH)) sif ();

   serial_sub_4b #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every done must match the oldest outstanding expectation
   initial begin
      forever begin
         @(negedge clk);
         if (sif.done === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_done: got diff=%b bout=%b with no op outstanding at %0t",
                        sif.diff, sif.bout, $time);
            end else begin
               logic [WIDTH:0] e;
               e = exp_q.pop_front();
               chk("result", 32'({sif.bout, sif.diff}), 32'(e));
            end
         end
      end
   end

   // Drive one op; optional mid-RUN restart attempt and optional reset at RUN-cycle rst_k
   task automatic run_op(input logic [3:0] a_v, input logic [3:0] b_v, input logic bin_v,
                         input bit mid_start, input int rst_k, input bit chk_timing);
      int tmp;
      int k;
      int busy_n;
      logic [WIDTH:0] e;
      tmp = int'(a_v) - int'(b_v) - int'(bin_v);
      e   = tmp[WIDTH:0];
      if (rst_k == 0) exp_q.push_back(e);
      sif.a     = a_v;
      sif.b     = b_v;
      sif.bin   = bin_v;
      sif.start = 1'b1;
      busy_n    = 0;
      for (k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (k == 1) begin
            sif.start = 1'b0;
            sif.a     = ~a_v;
            sif.b     = ~b_v;
            sif.bin   = ~bin_v;
         end
         if (mid_start && k == 2) begin
            sif.start = 1'b1;
            sif.a     = 4'b0000;
            sif.b     = 4'b0110;
         end
         if (mid_start && k == 3) sif.start = 1'b0;
         if (rst_k != 0 && k == rst_k + 1) begin
            rst = 1'b0;
            chk("rst_diff", 32'(sif.diff), 32'd0);
            chk("rst_bout", 32'(sif.bout), 32'd0);
            chk("rst_busy", 32'(sif.busy), 32'd0);
            chk("rst_done", 32'(sif.done), 32'd0);
            break;
         end
         if (rst_k != 0 && k == rst_k) rst = 1'b1;
         if (sif.busy === 1'b1) busy_n++;
         if (sif.done === 1'b1) begin
            if (chk_timing) begin
               chk("done_latency", 32'(k), 32'(WIDTH + 1));
               chk("busy_cycles", 32'(busy_n), 32'(WIDTH));
            end
            break;
         end
         if (k == 24) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: got no done after %0d cycles expected done at %0d", k, WIDTH + 1);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      sif.start = 1'b0;
      sif.a     = '0;
      sif.b     = '0;
      sif.bin   = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_diff", 32'(sif.diff), 32'd0);
      chk("reset_bout", 32'(sif.bout), 32'd0);
      chk("reset_busy", 32'(sif.busy), 32'd0);
      chk("reset_done", 32'(sif.done), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Zero operands with handshake timing
      run_op(4'b0000, 4'b0000, 1'b0, 1'b0, 0, 1'b1);

      // Directed vectors
      run_op(4'b0100, 4'b1001, 1'b1, 1'b0, 0, 1'b1);
      run_op(4'b0011, 4'b1000, 1'b0, 1'b0, 0, 1'b1);
      run_op(4'b1001, 4'b0110, 1'b1, 1'b0, 0, 1'b1);
      run_op(4'b0111, 4'b0001, 1'b1, 1'b0, 0, 1'b1);

      // Restart attempt during RUN must be ignored
      run_op(4'b1111, 4'b0001, 1'b0, 1'b1, 0, 1'b1);
      repeat (8) @(negedge clk);

      // Reset on the second RUN cycle abandons the op
      run_op(4'b0101, 4'b0011, 1'b0, 1'b0, 2, 1'b0);
      repeat (6) @(negedge clk);
      run_op(4'b0101, 4'b0011, 1'b0, 1'b0, 0, 1'b1);

      // Result hold while idle
      run_op(4'b1000, 4'b0001, 1'b0, 1'b0, 0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_diff", 32'(sif.diff), 32'b0111);
         chk("hold_bout", 32'(sif.bout), 32'd0);
         chk("hold_done", 32'(sif.done), 32'd0);
      end

      // Exhaustive sweep
      for (int av = 0; av < 16; av++)
         for (int bv = 0; bv < 16; bv++)
            for (int ci = 0; ci < 2; ci++)
               run_op(4'(av), 4'(bv), 1'(ci), 1'b0, 0, 1'b0);

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
